// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB first, load_reps+1 frames, GAP idle slots between frames.
// Latency: the MSB is presented in the cycle after the load edge; one bit or gap slot is consumed per advanced edge.
// Backpressure: advance=0 freezes all state, so outputs hold; loads are taken only in IDLE and are ignored otherwise.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [CNT_W-1:0] i_load_reps,
  input  logic             i_advance,
  input  logic             i_abort,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  output logic             o_frame_start,
  output logic             o_done
);

  localparam int BW = $clog2(WIDTH);
  // A zero-length gap still needs a legal counter; it is simply never loaded.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_pattern;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_done;
  logic             w_last_bit;
  logic             w_last_rep;
  logic             w_last_gap;

  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_last_rep = (r_rep_cnt == '0);
  assign w_last_gap = (r_gap_cnt == GAP_ONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; abort overrides everything else.
  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_load_valid) w_next = S_SHIFT;
        S_SHIFT: begin
          if (i_advance && w_last_bit) begin
            if (w_last_rep)   w_next = S_IDLE;
            else if (GAP > 0) w_next = S_GAP;
            else              w_next = S_SHIFT;
          end
        end
        S_GAP:   if (i_advance && w_last_gap) w_next = S_SHIFT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: pattern capture, shifting, frame/gap counting and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pattern <= '0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else if (i_abort) begin
      r_shreg <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load_valid) begin
            r_pattern <= i_load_data;
            r_shreg   <= i_load_data;
            r_rep_cnt <= i_load_reps;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (i_advance) begin
            if (!w_last_bit) begin
              r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_last_rep) begin
              r_done <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt - 1'b1;
              r_shreg   <= r_pattern;
              r_bit_cnt <= '0;
              if (GAP > 0) r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (i_advance) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    o_load_ready  = 1'b0;
    o_ser_out     = 1'b0;
    o_ser_valid   = 1'b0;
    o_frame_start = 1'b0;
    o_done        = r_done;
    case (r_state)
      S_IDLE:  o_load_ready = 1'b1;
      S_SHIFT: begin
        o_ser_valid   = 1'b1;
        o_ser_out     = r_shreg[WIDTH-1];
        o_frame_start = (r_bit_cnt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: a reference model expands each accepted load into
// the expected sequence of bit/gap slots; a monitor checks the presented slot every busy cycle.
// Directed cases cover the listed scenarios, then randomized jobs with random advance, busy loads and aborts.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_reps;
  logic             advance;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             done;

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_data  (load_data),
    .i_load_reps  (load_reps),
    .i_advance    (advance),
    .i_abort      (abort),
    .o_ser_out    (ser_out),
    .o_ser_valid  (ser_valid),
    .o_frame_start(frame_start),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic vld;
    logic dat;
    logic fs;
  } slot_t;

  slot_t sq[$];
  int    exp_done  = 0;
  bit    abort_chk = 1'b0;
  int    checks    = 0;
  int    failures  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a job is its frame bits MSB first, repeated reps+1 times, GAP empty slots in between.
  function automatic void push_job(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
    slot_t s;
    for (int f = 0; f <= int'(r); f++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        s.vld = 1'b1;
        s.dat = d[i];
        s.fs  = (i == WIDTH - 1);
        sq.push_back(s);
      end
      if (f < int'(r)) begin
        for (int g = 0; g < GAP; g++) sq.push_back(slot_t'(3'b000));
      end
    end
    exp_done++;
  endfunction

  // Model: watches the load handshake and abort at each active edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sq.delete();
        exp_done  = 0;
        abort_chk = 1'b0;
      end else if (abort) begin
        sq.delete();
        exp_done  = 0;
        abort_chk = 1'b1;
      end else if (load_valid && load_ready) begin
        push_job(load_data, load_reps);
      end
    end
  end

  // Monitor: compares presented slot / done / idle outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (abort_chk) begin
          chk("abort_to_idle", 32'({load_ready, ser_valid, done}), 32'b100);
          abort_chk = 1'b0;
        end
        if (done) begin
          chk("done_expected", 32'(exp_done > 0), 32'd1);
          if (exp_done > 0) exp_done--;
          chk("done_after_stream", 32'(sq.size()), 32'd0);
        end
        if (!load_ready) begin
          chk("busy_has_job", 32'(sq.size() != 0), 32'd1);
          if (sq.size() != 0) begin
            chk("serial_slot", 32'({ser_valid, ser_out, frame_start}), 32'(sq[0]));
            if (advance) void'(sq.pop_front());
          end
        end else begin
          chk("idle_outputs", 32'({ser_valid, ser_out, frame_start}), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] r);
    int n;
    n = 0;
    while (!load_ready && n < 500) begin
      step();
      n++;
    end
    chk("ready_before_load", 32'(load_ready), 32'd1);
    load_data  = d;
    load_reps  = r;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  // Runs cycles from cycle 1 of a job until done is seen; n returns the done cycle.
  task automatic wait_done(input bit adv_rand, input int stall_at, input int stall_len,
                           input int busy_at, input int abort_at, output int n);
    n = 1;
    while (!done && n < 600) begin
      if (adv_rand) advance = ($urandom_range(0, 3) != 0);
      else          advance = !(n >= stall_at && n < stall_at + stall_len);
      load_valid = (n == busy_at);
      if (n == busy_at) begin
        load_data = 8'hFF;
        load_reps = CNT_W'($urandom);
      end
      abort = (n == abort_at);
      step();
      n++;
      load_valid = 1'b0;
      if (abort) begin
        abort = 1'b0;
        return;
      end
    end
    chk("done_within_bound", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] r;
    int busy;
    int ab;

    load_valid = 1'b1;
    load_data  = 8'hAA;
    load_reps  = '0;
    advance    = 1'b1;
    abort      = 1'b0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({load_ready, ser_valid, ser_out, frame_start, done}), 32'b10000);
    load_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_reset_idle", 32'({load_ready, ser_valid, ser_out, frame_start, done}), 32'b10000);

    // Single frame A5.
    start_load(8'hA5, 4'd0);
    chk("a5_first_msb", 32'({ser_valid, ser_out, frame_start, load_ready}), 32'b1110);
    wait_done(1'b0, 0, 0, 0, 0, n);
    chk("a5_done_cycle", 32'(n), 32'd9);
    chk("a5_ready_at_done", 32'(load_ready), 32'd1);

    // Two frames of C3 with the gap.
    start_load(8'hC3, 4'd1);
    wait_done(1'b0, 0, 0, 0, 0, n);
    chk("c3_done_cycle", 32'(n), 32'd19);

    // Stall three cycles while bit 2 is presented.
    start_load(8'hA5, 4'd0);
    wait_done(1'b0, 3, 3, 0, 0, n);
    chk("stall_done_cycle", 32'(n), 32'd12);

    // Busy load ignored, then back-to-back load in the done cycle.
    start_load(8'hA5, 4'd0);
    wait_done(1'b0, 0, 0, 5, 0, n);
    chk("busy_done_cycle", 32'(n), 32'd9);
    start_load(8'h81, 4'd0);
    chk("b2b_msb", 32'({ser_valid, ser_out, frame_start}), 32'b111);
    wait_done(1'b0, 0, 0, 0, 0, n);
    chk("b2b_done_cycle", 32'(n), 32'd9);

    // Abort at bit 5 of the first of three frames.
    start_load(8'h5A, 4'd2);
    wait_done(1'b0, 0, 0, 0, 6, n);
    chk("abort_state", 32'({load_ready, ser_valid, done}), 32'b100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Asynchronous reset in the middle of a gap slot.
    start_load(8'hC3, 4'd1);
    advance = 1'b1;
    repeat (8) step();
    chk("in_gap", 32'({load_ready, ser_valid}), 32'b00);
    #1 rst = 1'b1;
    #1 chk("async_reset", 32'({load_ready, ser_valid, ser_out, frame_start, done}), 32'b10000);
    #1 rst = 1'b0;
    start_load(8'h01, 4'd0);
    wait_done(1'b0, 0, 0, 0, 0, n);
    chk("post_reset_done_cycle", 32'(n), 32'd9);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      d    = WIDTH'($urandom);
      r    = CNT_W'($urandom_range(0, 3));
      busy = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 8)) : 0;
      ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 8)) : 0;
      start_load(d, r);
      wait_done(1'b1, 0, 0, busy, ab, n);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    chk("queue_drained", 32'(sq.size()), 32'd0);
    chk("no_pending_done", 32'(exp_done), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: accepts a parallel WIDTH-bit pattern plus a repeat count over a valid/ready load port. It shifts the pattern out one bit per advanced cycle, MSB first, and repeats it with a fixed idle gap between frames. It is the driving end of the single-bit serial input consumed by the team's Mealy sequence-detector FSMs, and replaces the random bit stimulus with deterministic framed streams.

## Interface
- WIDTH, 8: pattern length in bits (≥2).
- CNT_W, 4: repeat-count width.
- GAP, 2: idle bit-slots between repeated frames (0 allowed).

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load request.
- load_ready  out  1  high when the block can accept a load.
- load_data  in  WIDTH  pattern; bit WIDTH-1 is sent first.
- load_reps  in  CNT_W  extra repetitions; total frames sent = load_reps+1.
- advance  in  1  consumer strobe; a bit or gap slot is consumed only on an edge with advance=1.
- abort  in  1  synchronous cancel.
- ser_out  out  1  serial data bit; 0 when no frame bit is presented.
- ser_valid  out  1  ser_out carries a frame bit.
- frame_start  out  1  ser_valid and the bit presented is bit 0 of a frame (the MSB).
- done  out  1  one-cycle pulse after the last bit of the last frame is consumed.

## Operation
- Registers: pattern (WIDTH), shreg (WIDTH), bit_cnt (ceil log2 WIDTH), rep_cnt (CNT_W), gap_cnt (ceil log2(GAP+1)), state, done.
- States:
  - IDLE: load_ready=1.
  - SHIFT: load_ready=0, ser_valid=1.
  - GAP: load_ready=0, ser_valid=0.
- IDLE, on load_valid=1:
  - pattern←load_data, shreg←load_data, rep_cnt←load_reps, bit_cnt←0.
  - Go to SHIFT.
- SHIFT, combinational outputs: ser_out=shreg[WIDTH-1]; frame_start=(bit_cnt==0).
- SHIFT, on edge with advance=1:
  - Not last bit (bit_cnt<WIDTH-1): shreg shifts left with 0 fill; bit_cnt++.
  - Last bit, rep_cnt==0: go to IDLE; done←1.
  - Last bit, rep_cnt>0: rep_cnt--; shreg←pattern; bit_cnt←0.
    - GAP>0: gap_cnt←GAP; go to GAP.
    - GAP==0: stay in SHIFT. The next frame's MSB follows with no idle slot.
- SHIFT, advance=0: all registers hold. Outputs are stable through stalls.
- GAP: ser_out=0. Each edge with advance=1 decrements gap_cnt; when gap_cnt reaches 1, go to SHIFT.
- abort=1 in any state: go to IDLE next edge, done stays 0, shreg←0. abort has priority over advance and load_valid.
- load_valid while load_ready=0: ignored, nothing latched. The upstream holds or retries.
- done is registered and high only in the first IDLE cycle. load_valid in that same cycle is accepted, so back-to-back jobs are allowed.

## Timing
- Reset values (async, while rst=1 and after release):
  - state IDLE; shreg, pattern, bit_cnt, rep_cnt, gap_cnt all 0.
  - ser_out=0, ser_valid=0, frame_start=0, done=0, load_ready=1.
  - load_valid is ignored while rst=1.
- Load accepted at edge k: the MSB is presented (ser_valid=1, frame_start=1) in the cycle after edge k.
- Bit i of a frame is presented after i advanced edges within that frame.
- With advance tied high and N=load_reps+1 frames:
  - The stream occupies N·WIDTH + (N-1)·GAP cycles.
  - done is high in the following cycle.
- rst asserted mid-frame: outputs go to reset values immediately, without waiting for clk.
- Outputs depend only on registered state. There is no combinational path from advance or load_valid to any output. load_ready is a decode of state.

## Test plan
- Single frame: WIDTH=8, load_data=8'hA5, load_reps=0, advance=1.
  - ser_out = 1,0,1,0,0,1,0,1 in cycles 1..8 after load, ser_valid=1 throughout, frame_start only in cycle 1.
  - done=1 in cycle 9; load_ready 0 in cycles 1..8, 1 in cycle 9.
- Repeat with gap: 8'hC3, load_reps=1, GAP=2.
  - ser_out = 11000011, then two cycles of ser_valid=0/ser_out=0, then 11000011 with frame_start on the first bit of each frame.
  - done in cycle 19.
- Stall: 8'hA5, advance=0 for 3 cycles while bit 2 (value 1) is presented.
  - ser_out=1, ser_valid=1 held for all 3 cycles; the total stream stretches to 11 cycles; bit order unchanged.
- Busy/back-to-back: load_valid=1 with 8'hFF during bit 4 of a running frame.
  - Ignored; the current frame completes unchanged.
  - A load of 8'h81 presented in the done cycle is accepted: MSB 1 appears in the next cycle.
- Abort: abort=1 at bit 5 of frame 1 of 3.
  - Next cycle: IDLE, ser_valid=0, load_ready=1, done never pulses.
- Async reset: rst pulsed mid-GAP between clock edges.
  - All outputs at reset values before the next edge; a fresh load of 8'h01 then produces 0000_0001.
